// File: rtl/knock_pkg.sv
// Knock conditioner shared definitions: FSM state encoding, default timing
// constants (in CLK1K cycles) and the statistics counter width.
package knock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PULSE    = 2'd2,
        HOLDOFF  = 2'd3
    } knock_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_MS      = 5;
    localparam int DEF_PULSE_MS    = 20;
    localparam int DEF_HOLDOFF_MS  = 200;

    localparam int STATS_W = 8;

    // Largest of the three timing windows; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/knock_sync.sv
// Multi-stage synchronizer for the asynchronous piezo/comparator input.
// Flops clear to 0 so a reset never presents a phantom press to the FSM.
module knock_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK1K,
    input  logic RSTN,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/knock_conditioner.sv
// Knock conditioner: synchronizes and debounces the raw knock sensor and
// emits one fixed-width active-low KNOCK pulse per accepted knock, followed
// by a hold-off window that swallows sensor ringing.
// Optional build macro KNOCK_STATS_EN adds saturating accepted/glitch counters
// (KNOCK_CNT, GLITCH_CNT); KNOCK/BUSY behave identically either way.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | waiting for a synchronized press, KNOCK high
//   DEBOUNCE | counting consecutive high samples; a low sample aborts
//   PULSE    | KNOCK held low for PULSE_MS cycles, input ignored
//   HOLDOFF  | input ignored for HOLDOFF_MS cycles, then wait for release
module knock_conditioner
    import knock_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_MS      = DEF_DEB_MS,
    parameter int PULSE_MS    = DEF_PULSE_MS,
    parameter int HOLDOFF_MS  = DEF_HOLDOFF_MS
) (
    input  logic               CLK1K,
    input  logic               RSTN,
    input  logic               KNOCK_RAW,
    output logic               KNOCK,
    output logic               BUSY
`ifdef KNOCK_STATS_EN
    ,
    output logic [STATS_W-1:0] KNOCK_CNT,
    output logic [STATS_W-1:0] GLITCH_CNT
`endif
);

    localparam int CNT_MAX = max3(DEB_MS, PULSE_MS, HOLDOFF_MS);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal values: each phase ends when the counter reaches its last value.
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_MS - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_MS - 1);
    localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(HOLDOFF_MS);

    logic             raw_s;
    knock_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             knock_nxt;
    logic             busy_nxt;

    knock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK1K (CLK1K),
        .RSTN  (RSTN),
        .d     (KNOCK_RAW),
        .q     (raw_s)
    );

    // State, phase counter and registered outputs.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            cnt   <= '0;
            KNOCK <= 1'b1;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            KNOCK <= knock_nxt;
            BUSY  <= busy_nxt;
        end
    end

    // Next-state, counter update and output decode; the counter saturates at
    // each phase's terminal value and is cleared on every state change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (raw_s) begin
                    state_nxt = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (!raw_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PULSE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = HOLDOFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            HOLDOFF: begin
                if (cnt != HOLD_END) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (!raw_s) begin
                    // Release re-arm: a held input never produces a second knock.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        knock_nxt = (state_nxt != PULSE);
        busy_nxt  = (state_nxt != IDLE);
    end

`ifdef KNOCK_STATS_EN
    logic knock_accept;
    logic glitch_abort;

    assign knock_accept = (state_nxt == PULSE) && (state != PULSE);
    assign glitch_abort = (state == DEBOUNCE) && (state_nxt == IDLE);

    // Saturating accepted-knock and glitch counters, cleared only by reset.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            KNOCK_CNT  <= '0;
            GLITCH_CNT <= '0;
        end else begin
            if (knock_accept && (KNOCK_CNT != '1)) begin
                KNOCK_CNT <= KNOCK_CNT + 1'b1;
            end
            if (glitch_abort && (GLITCH_CNT != '1)) begin
                GLITCH_CNT <= GLITCH_CNT + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_knock_conditioner.sv
// Directed bench for knock_conditioner at default timing. Edge numbering
// follows the raw input: edge 1 is the first rising CLK1K edge after
// KNOCK_RAW changes. Statistics checks build only with KNOCK_STATS_EN.
module tb_knock_conditioner;

    logic       CLK1K     = 1'b0;
    logic       RSTN      = 1'b0;
    logic       KNOCK_RAW = 1'b0;
    logic       KNOCK;
    logic       BUSY;
`ifdef KNOCK_STATS_EN
    logic [7:0] KNOCK_CNT;
    logic [7:0] GLITCH_CNT;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int falls  = 0;
    int f0     = 0;
    logic knock_prev = 1'b1;

    knock_conditioner dut (
        .CLK1K      (CLK1K),
        .RSTN       (RSTN),
        .KNOCK_RAW  (KNOCK_RAW),
        .KNOCK      (KNOCK),
        .BUSY       (BUSY)
`ifdef KNOCK_STATS_EN
        ,
        .KNOCK_CNT  (KNOCK_CNT),
        .GLITCH_CNT (GLITCH_CNT)
`endif
    );

    always #5 CLK1K = ~CLK1K;

    // Count KNOCK falling edges, sampled away from the active edge.
    always @(negedge CLK1K) begin
        if (knock_prev === 1'b1 && KNOCK === 1'b0) falls++;
        knock_prev = KNOCK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK1K);
            #1;
        end
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        int k;
        k = 0;
        while (BUSY !== 1'b0 && k < max_cycles) begin
            step(1);
            k++;
        end
        check(tag, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        // Reset
        step(3);
        check("rst_knock", {31'd0, KNOCK}, 32'd1);
        check("rst_busy",  {31'd0, BUSY},  32'd0);
        RSTN = 1'b1;
        step(2);
`ifdef KNOCK_STATS_EN
        check("rst_kcnt", {24'd0, KNOCK_CNT},  32'd0);
        check("rst_gcnt", {24'd0, GLITCH_CNT}, 32'd0);
`endif

        // 1: clean 30-cycle press
        f0 = falls;
        KNOCK_RAW = 1'b1;
        step(2);
        check("s1_busy_e2",  {31'd0, BUSY},  32'd0);
        step(2);
        check("s1_busy_e4",  {31'd0, BUSY},  32'd1);
        step(3);
        check("s1_knock_e7", {31'd0, KNOCK}, 32'd1);
        step(1);
        check("s1_knock_e8", {31'd0, KNOCK}, 32'd0);
        step(19);
        check("s1_knock_e27", {31'd0, KNOCK}, 32'd0);
        step(1);
        check("s1_knock_e28", {31'd0, KNOCK}, 32'd1);
        check("s1_busy_e28",  {31'd0, BUSY},  32'd1);
        step(2);
        KNOCK_RAW = 1'b0;
        wait_idle(300, "s1_idle_timeout");
        check("s1_pulses", falls - f0, 32'd1);

        // 2: 3-cycle glitch
        step(5);
        f0 = falls;
        KNOCK_RAW = 1'b1;
        step(3);
        KNOCK_RAW = 1'b0;
        step(1);
        check("s2_busy_e4", {31'd0, BUSY}, 32'd1);
        step(3);
        check("s2_busy_e7", {31'd0, BUSY}, 32'd0);
        check("s2_pulses", falls - f0, 32'd0);
`ifdef KNOCK_STATS_EN
        check("s2_gcnt", {24'd0, GLITCH_CNT}, 32'd1);
`endif

        // 3: accepted knock followed by ringing
        f0 = falls;
        KNOCK_RAW = 1'b1;
        step(30);
        for (int i = 0; i < 50; i++) begin
            KNOCK_RAW = ~KNOCK_RAW;
            step(3);
        end
        KNOCK_RAW = 1'b0;
        wait_idle(300, "s3_idle_timeout");
        check("s3_pulses", falls - f0, 32'd1);
`ifdef KNOCK_STATS_EN
        check("s3_kcnt", {24'd0, KNOCK_CNT},  32'd2);
        check("s3_gcnt", {24'd0, GLITCH_CNT}, 32'd1);
`endif

        // 4: long hold, release, re-press
        f0 = falls;
        KNOCK_RAW = 1'b1;
        step(500);
        check("s4_hold_busy",   {31'd0, BUSY},  32'd1);
        check("s4_hold_knock",  {31'd0, KNOCK}, 32'd1);
        check("s4_hold_pulses", falls - f0, 32'd1);
        KNOCK_RAW = 1'b0;
        step(5);
        check("s4_release_busy", {31'd0, BUSY}, 32'd0);
        KNOCK_RAW = 1'b1;
        step(7);
        check("s4_repress_e7", {31'd0, KNOCK}, 32'd1);
        step(1);
        check("s4_repress_e8", {31'd0, KNOCK}, 32'd0);
        step(22);
        KNOCK_RAW = 1'b0;
        wait_idle(300, "s4_idle_timeout");
        check("s4_pulses", falls - f0, 32'd2);

        // 5: async reset during PULSE
        KNOCK_RAW = 1'b1;
        step(8);
        check("s5_in_pulse", {31'd0, KNOCK}, 32'd0);
        step(9);
        #2;
        RSTN = 1'b0;
        #1;
        check("s5_rst_knock", {31'd0, KNOCK}, 32'd1);
        check("s5_rst_busy",  {31'd0, BUSY},  32'd0);
        KNOCK_RAW = 1'b0;
        step(2);
        RSTN = 1'b1;
        step(2);
`ifdef KNOCK_STATS_EN
        check("s5_rst_kcnt", {24'd0, KNOCK_CNT}, 32'd0);
`endif
        f0 = falls;
        KNOCK_RAW = 1'b1;
        step(7);
        check("s5_restart_e7", {31'd0, KNOCK}, 32'd1);
        step(1);
        check("s5_restart_e8", {31'd0, KNOCK}, 32'd0);
        step(20);
        check("s5_restart_e28", {31'd0, KNOCK}, 32'd1);
        step(2);
        KNOCK_RAW = 1'b0;
        wait_idle(300, "s5_idle_timeout");
        check("s5_pulses", falls - f0, 32'd1);

`ifdef KNOCK_STATS_EN
        // 6: counter saturation over 260 knocks
        f0 = falls;
        for (int k = 0; k < 260; k++) begin
            KNOCK_RAW = 1'b1;
            step(30);
            KNOCK_RAW = 1'b0;
            step(270);
        end
        check("s6_pulses", falls - f0, 32'd260);
        check("s6_kcnt", {24'd0, KNOCK_CNT},  32'd255);
        check("s6_gcnt", {24'd0, GLITCH_CNT}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
